// File: rtl/btn_cfg_ctrl.sv
// Push-button front end for the traffic-light duration configuration: sync, debounce, one pulse per press.
// Optional AUTOREPEAT_EN adds hold-to-repeat pulses on the latched colour line.
module btn_cfg_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic       btn,
  output logic       control_r_out,
  output logic       control_y_out,
  output logic       control_g_out,
  output logic       first_out,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, PRESS_DB, FIRE, HELD, REL_DB} state_t;

  state_t      state, next_state;
  logic        sync_p0, sync_p1;
  logic        btn_s;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  sel, sel_nxt;
  logic        rep_fire;
  logic        r_d, y_d, g_d, first_d, busy_d;
  logic        fire_d;
  logic [1:0]  pulse_sel;

  if (DEBOUNCE_CYCLES == 16'd0) begin : g_bad_debounce
    $error("btn_cfg_ctrl: DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_DELAY == 24'd0 || REPEAT_PERIOD == 24'd0) begin : g_bad_repeat
    $error("btn_cfg_ctrl: REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
  end

  // Stage p0/p1: two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  assign btn_s = sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 16'd0;
      sel   <= 2'b00;
    end else begin
      state <= next_state;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
    end
  end

  // cnt never exceeds DEBOUNCE_CYCLES, so the >= compares also keep it from wrapping
  always_comb begin
    next_state = state;
    cnt_nxt    = cnt;
    sel_nxt    = sel;
    case (state)
      IDLE: begin
        if (btn_s) begin
          next_state = PRESS_DB;
          cnt_nxt    = 16'd1;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          next_state = IDLE;
        end else if (cnt >= DEBOUNCE_CYCLES) begin
          next_state = FIRE;
          sel_nxt    = sw;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      FIRE: next_state = HELD;
      HELD: begin
        if (!btn_s) begin
          next_state = REL_DB;
          cnt_nxt    = 16'd1;
        end
      end
      REL_DB: begin
        if (btn_s) begin
          next_state = HELD;
        end else if (cnt >= DEBOUNCE_CYCLES) begin
          next_state = IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef AUTOREPEAT_EN
  logic [23:0] hold_tmr;
  logic        rep_phase;

  // rep_phase selects the initial delay versus the steady repeat period
  always_comb begin
    rep_fire = (state == HELD) && (next_state == HELD) &&
               ((hold_tmr + 24'd1) == (rep_phase ? REPEAT_PERIOD : REPEAT_DELAY));
  end

  always_ff @(posedge clk) begin
    if (rst || state != HELD || next_state != HELD) begin
      hold_tmr  <= 24'd0;
      rep_phase <= 1'b0;
    end else if (rep_fire) begin
      hold_tmr  <= 24'd0;
      rep_phase <= 1'b1;
    end else begin
      hold_tmr <= hold_tmr + 24'd1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Outputs are decoded from the next state so the registered pulse lines up with FIRE
  always_comb begin
    fire_d    = (next_state == FIRE) || rep_fire;
    pulse_sel = (next_state == FIRE) ? sel_nxt : sel;
    r_d       = fire_d && (pulse_sel == 2'b11);
    y_d       = fire_d && (pulse_sel == 2'b01);
    g_d       = fire_d && (pulse_sel == 2'b10);
    first_d   = ((next_state == HELD) || (next_state == REL_DB)) && !rep_fire;
    busy_d    = (next_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      control_r_out <= 1'b0;
      control_y_out <= 1'b0;
      control_g_out <= 1'b0;
      first_out     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      control_r_out <= r_d;
      control_y_out <= y_d;
      control_g_out <= g_d;
      first_out     <= first_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_btn_cfg_ctrl.sv
// Scoreboard bench for btn_cfg_ctrl: expected pulses queued at stimulus time, popped when a pulse appears.
module tb_btn_cfg_ctrl;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam logic [2:0] LN_R = 3'b100;
  localparam logic [2:0] LN_Y = 3'b010;
  localparam logic [2:0] LN_G = 3'b001;

  logic       clk;
  logic       rst;
  logic [1:0] sw;
  logic       btn;
  logic       control_r_out, control_y_out, control_g_out, first_out, busy;

  btn_cfg_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY   (24'd10),
    .REPEAT_PERIOD  (24'd5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .btn          (btn),
    .control_r_out(control_r_out),
    .control_y_out(control_y_out),
    .control_g_out(control_g_out),
    .first_out    (first_out),
    .busy         (busy)
  );

  typedef struct {
    int         cyc;
    logic [2:0] lines;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   edge_n = 0;
  bit   mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n = edge_n + 1;

  // Pulse monitor: every observed pulse must match the head of the expectation queue
  always @(negedge clk) begin
    logic [2:0] seen;
    exp_t       e;
    seen = {control_r_out, control_y_out, control_g_out};
    if (mon_en && seen !== 3'b000) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_pulse: lines %b at edge %0d, none expected", seen, edge_n);
      end else begin
        e = exp_q.pop_front();
        if (seen !== e.lines || edge_n != e.cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL pulse: lines %b at edge %0d, expected %b at edge %0d",
                   seen, edge_n, e.lines, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model of a clean press driven right after edge e0 and released right after edge e0+h
  function automatic bit exp_rep(int k, int h);
`ifdef AUTOREPEAT_EN
    return (k >= D + 4 + RD) && (k <= h + 2) && (((k - (D + 4 + RD)) % RP) == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_first(int k, int h);
    return (k >= D + 4) && (k <= h + D + 2) && !exp_rep(k, h);
  endfunction

  function automatic bit exp_busy(int k, int h);
    return (k >= 3) && (k <= h + D + 2);
  endfunction

  task automatic push_press(int e0, int h, logic [2:0] lines);
    exp_t e;
    if (lines == 3'b000) return;
    e.lines = lines;
    e.cyc   = e0 + D + 3;
    exp_q.push_back(e);
    for (int k = D + 4 + RD; k <= h + 2; k += RP) begin
      if (exp_rep(k, h)) begin
        e.cyc = e0 + k;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    int e0;
    int h = 10;
    rst = 1'b1;
    btn = 1'b1;
    sw  = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp = n_cmp + 1;
      if ({control_r_out, control_y_out, control_g_out, first_out, busy} !== 5'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL reset_outputs: got %b, required 00000",
                 {control_r_out, control_y_out, control_g_out, first_out, busy});
      end
    end
    mon_en = 1'b1;
    rst    = 1'b0;
    e0     = edge_n;
    push_press(e0, h, LN_Y);
    for (int k = 1; k <= h + D + 4; k++) begin
      step();
      n_cmp = n_cmp + 1;
      if (first_out !== exp_first(k, h) || busy !== exp_busy(k, h)) begin
        n_fail = n_fail + 1;
        $display("FAIL reset_release k=%0d: first/busy %b%b, required %b%b",
                 k, first_out, busy, exp_first(k, h), exp_busy(k, h));
      end
      if (k == h) btn = 1'b0;
    end
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_single_y();
    int e0;
    int h = 20;
    sw  = 2'b01;
    btn = 1'b1;
    e0  = edge_n;
    push_press(e0, h, LN_Y);
    for (int k = 1; k <= h + D + 4; k++) begin
      step();
      n_cmp = n_cmp + 1;
      if (first_out !== exp_first(k, h) || busy !== exp_busy(k, h)) begin
        n_fail = n_fail + 1;
        $display("FAIL single_y k=%0d: first/busy %b%b, required %b%b",
                 k, first_out, busy, exp_first(k, h), exp_busy(k, h));
      end
      if (k == h) btn = 1'b0;
    end
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL single_y_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_glitch();
    sw  = 2'b11;
    btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 2) btn = 1'b0;
      n_cmp = n_cmp + 1;
      if (busy !== (k == 3 || k == 4) || first_out !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL glitch k=%0d: first/busy %b%b, required 0%b",
                 k, first_out, busy, (k == 3 || k == 4));
      end
    end
  endtask

  task automatic test_release_bounce();
    int e0;
    bit ef;
    sw  = 2'b11;
    btn = 1'b1;
    e0  = edge_n;
    push_press(e0, 10, LN_R);
    for (int k = 1; k <= 26; k++) begin
      step();
      ef = (k >= 8) && (k <= 21);
      n_cmp = n_cmp + 1;
      if (first_out !== ef || busy !== ((k >= 3) && (k <= 21))) begin
        n_fail = n_fail + 1;
        $display("FAIL release_bounce k=%0d: first/busy %b%b, required %b%b",
                 k, first_out, busy, ef, ((k >= 3) && (k <= 21)));
      end
      if (k == 10) btn = 1'b0;
      if (k == 12) btn = 1'b1;
      if (k == 15) btn = 1'b0;
    end
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL release_bounce_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_sel_latch();
    int e0;
    int h;
    h   = 10;
    sw  = 2'b10;
    btn = 1'b1;
    e0  = edge_n;
    push_press(e0, h, LN_G);
    for (int k = 1; k <= h + D + 4; k++) begin
      step();
      n_cmp = n_cmp + 1;
      if (first_out !== exp_first(k, h) || busy !== exp_busy(k, h)) begin
        n_fail = n_fail + 1;
        $display("FAIL sel_latch k=%0d: first/busy %b%b, required %b%b",
                 k, first_out, busy, exp_first(k, h), exp_busy(k, h));
      end
      if (k == h) btn = 1'b0;
      if (k == h + 4) sw = 2'b11;
    end
    h   = 12;
    sw  = 2'b00;
    btn = 1'b1;
    e0  = edge_n;
    push_press(e0, h, 3'b000);
    for (int k = 1; k <= h + D + 4; k++) begin
      step();
      n_cmp = n_cmp + 1;
      if (first_out !== exp_first(k, h) || busy !== exp_busy(k, h)) begin
        n_fail = n_fail + 1;
        $display("FAIL sel_run k=%0d: first/busy %b%b, required %b%b",
                 k, first_out, busy, exp_first(k, h), exp_busy(k, h));
      end
      if (k == h) btn = 1'b0;
    end
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL sel_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_autorepeat();
    int e0;
    int h = 36;
    sw  = 2'b01;
    btn = 1'b1;
    e0  = edge_n;
    push_press(e0, h, LN_Y);
    for (int k = 1; k <= h + D + 4; k++) begin
      step();
      n_cmp = n_cmp + 1;
      if (first_out !== exp_first(k, h) || busy !== exp_busy(k, h)) begin
        n_fail = n_fail + 1;
        $display("FAIL autorepeat k=%0d: first/busy %b%b, required %b%b",
                 k, first_out, busy, exp_first(k, h), exp_busy(k, h));
      end
      if (k == h) btn = 1'b0;
    end
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL autorepeat_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    sw  = 2'b00;
    test_reset();
    test_single_y();
    test_glitch();
    test_release_bounce();
    test_sel_latch();
    test_autorepeat();
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
